// File: rtl/exe_pkg.sv
// Shared types for the execute stage: command codes, branch kinds, FSM states.
package exe_pkg;

    typedef enum logic [3:0] {
        CMD_ADD = 4'd0,
        CMD_SUB = 4'd1,
        CMD_AND = 4'd2,
        CMD_OR  = 4'd3,
        CMD_NOR = 4'd4,
        CMD_XOR = 4'd5,
        CMD_SLL = 4'd6,
        CMD_SRL = 4'd7,
        CMD_SRA = 4'd8,
        CMD_SLT = 4'd9,
        CMD_MUL = 4'd10
    } exe_cmd_e;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_BEZ  = 2'd1,
        BR_BNE  = 2'd2,
        BR_JMP  = 2'd3
    } br_type_e;

    typedef enum logic {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } exe_state_e;

endpackage

// File: rtl/exe_stage_mul.sv
// Iterative shift-add multiplier, one multiplier bit per step, XLEN steps.
// Only built when EXE_MUL_EN is defined; the default build carries no multiplier.
`ifdef EXE_MUL_EN
module seq_mul_unit #(
    parameter int XLEN    = 32,
    parameter int STEPS_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            step,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] product
);

    logic [STEPS_W-1:0] cnt;
    logic [XLEN-1:0]    acc;
    logic [XLEN-1:0]    mcand;
    logic [XLEN-1:0]    mplier;
    logic [XLEN-1:0]    acc_nxt;

    // Partial sum after this step; on the final step it is the low half of the product.
    always_comb begin
        acc_nxt = acc + (mplier[0] ? mcand : '0);
    end

    assign done    = step && (cnt == STEPS_W'(XLEN - 1));
    assign product = acc_nxt;

    // Operand load on start, then one shift-add per step; counter rewinds on the last step.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
        end else if (step) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= done ? '0 : cnt + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/exe_stage_mc.sv
// Registered execute stage: ALU, branch resolve, valid/ready output register.
// Optional iterative multiplier enabled by defining EXE_MUL_EN.
import exe_pkg::*;

module exe_stage_mc #(
    parameter int XLEN           = 32,
    parameter int CMD_W          = 4,
    parameter int MUL_STEPS_LOG2 = $clog2(XLEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    input  logic [CMD_W-1:0] exe_cmd,
    input  logic [1:0]       branch_type,
    input  logic [XLEN-1:0]  val1,
    input  logic [XLEN-1:0]  val2,
    input  logic [XLEN-1:0]  src2_val,
    input  logic [XLEN-1:0]  pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  alu_result,
    output logic [XLEN-1:0]  branch_address,
    output logic             branch_taken
);

    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] br_addr;
    logic            br_taken;
    logic            accept;
    logic            is_mul;
    logic            mul_done;
    logic [XLEN-1:0] mul_prod;

    assign shamt   = val2[SHW-1:0];
    assign br_addr = pc + val2;
    // A flush kills whatever would have been accepted in the same cycle.
    assign accept  = in_valid && in_ready && !flush;

    // Single-cycle ALU; unknown codes (and MUL, which is handled separately) give 0.
    always_comb begin
        alu_res = '0;
        case (exe_cmd)
            CMD_W'(CMD_ADD): alu_res = val1 + val2;
            CMD_W'(CMD_SUB): alu_res = val1 - val2;
            CMD_W'(CMD_AND): alu_res = val1 & val2;
            CMD_W'(CMD_OR):  alu_res = val1 | val2;
            CMD_W'(CMD_NOR): alu_res = ~(val1 | val2);
            CMD_W'(CMD_XOR): alu_res = val1 ^ val2;
            CMD_W'(CMD_SLL): alu_res = val1 << shamt;
            CMD_W'(CMD_SRL): alu_res = val1 >> shamt;
            CMD_W'(CMD_SRA): alu_res = XLEN'($signed(val1) >>> shamt);
            CMD_W'(CMD_SLT): alu_res = {{(XLEN-1){1'b0}}, ($signed(val1) < $signed(val2))};
            default:         alu_res = '0;
        endcase
    end

    // Branch resolution; the target is computed for every instruction.
    always_comb begin
        br_taken = 1'b0;
        case (br_type_e'(branch_type))
            BR_BEZ:  br_taken = (val1 == '0);
            BR_BNE:  br_taken = (val1 != src2_val);
            BR_JMP:  br_taken = 1'b1;
            default: br_taken = 1'b0;
        endcase
    end

`ifdef EXE_MUL_EN
    exe_state_e state;
    exe_state_e state_nxt;
    logic       mul_step;

    assign is_mul   = (exe_cmd == CMD_W'(CMD_MUL));
    assign mul_step = (state == MUL_BUSY) && !flush;
    assign in_ready = (state == IDLE) && (!out_valid || out_ready);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next state: MUL accept enters BUSY, last step or flush returns to IDLE.
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:     if (accept && is_mul) state_nxt = MUL_BUSY;
                MUL_BUSY: if (mul_done)         state_nxt = IDLE;
                default:  state_nxt = IDLE;
            endcase
        end
    end

    seq_mul_unit #(
        .XLEN    (XLEN),
        .STEPS_W (MUL_STEPS_LOG2)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (accept && is_mul),
        .step    (mul_step),
        .a       (val1),
        .b       (val2),
        .done    (mul_done),
        .product (mul_prod)
    );
`else
    assign is_mul   = 1'b0;
    assign mul_done = 1'b0;
    assign mul_prod = '0;
    assign in_ready = !out_valid || out_ready;
`endif

    // Output register: flush clears, multiply completion loads, accept replaces, consume drains.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid      <= 1'b0;
            alu_result     <= '0;
            branch_address <= '0;
            branch_taken   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (mul_done) begin
            out_valid  <= 1'b1;
            alu_result <= mul_prod;
        end else if (accept) begin
            branch_address <= br_addr;
            if (is_mul) begin
                // Result arrives later; a multiply never reports a taken branch.
                out_valid    <= 1'b0;
                branch_taken <= 1'b0;
            end else begin
                out_valid    <= 1'b1;
                alu_result   <= alu_res;
                branch_taken <= br_taken;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_exe_stage_mc.sv
// Self-checking bench for exe_stage_mc: vector table, scoreboard, corner sequences.
// Multiplier sequences run only when EXE_MUL_EN is defined.
module tb_exe_stage_mc;
    import exe_pkg::*;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic            flush = 1'b0;
    logic [3:0]      exe_cmd = '0;
    logic [1:0]      branch_type = '0;
    logic [XLEN-1:0] val1 = '0, val2 = '0, src2_val = '0, pc = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] alu_result, branch_address;
    logic            branch_taken;

    exe_stage_mc #(.XLEN(XLEN), .CMD_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .exe_cmd(exe_cmd), .branch_type(branch_type), .val1(val1), .val2(val2),
        .src2_val(src2_val), .pc(pc), .out_valid(out_valid), .out_ready(out_ready),
        .alu_result(alu_result), .branch_address(branch_address), .branch_taken(branch_taken)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [31:0] addr;
        logic        taken;
    } exp_t;

    typedef struct {
        logic [3:0]  cmd;
        logic [1:0]  bt;
        logic [31:0] v1, v2, s2, p;
        exp_t        e;
    } vec_t;

    localparam int NV = 19;
`ifdef EXE_MUL_EN
    localparam logic [31:0] MUL_3X4 = 32'd12;
`else
    localparam logic [31:0] MUL_3X4 = 32'd0;
`endif

    exp_t exp_q[$];
    vec_t tbl[NV];
    int   checks = 0;
    int   failures = 0;
    bit   rand_bp = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] cmd, input logic [1:0] bt,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] s2, input logic [31:0] p);
        exp_t e;
        e.addr = p + b;
        case (cmd)
            4'd0:  e.res = a + b;
            4'd1:  e.res = a - b;
            4'd2:  e.res = a & b;
            4'd3:  e.res = a | b;
            4'd4:  e.res = ~(a | b);
            4'd5:  e.res = a ^ b;
            4'd6:  e.res = a << b[4:0];
            4'd7:  e.res = a >> b[4:0];
            4'd8:  e.res = 32'($signed(a) >>> b[4:0]);
            4'd9:  e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
`ifdef EXE_MUL_EN
            4'd10: e.res = a * b;
`endif
            default: e.res = 32'd0;
        endcase
        case (bt)
            2'd1:    e.taken = (a == 32'd0);
            2'd2:    e.taken = (a != s2);
            2'd3:    e.taken = 1'b1;
            default: e.taken = 1'b0;
        endcase
`ifdef EXE_MUL_EN
        if (cmd == 4'd10) e.taken = 1'b0;
`endif
        return e;
    endfunction

    // Scoreboard: every transfer on the output side pops and compares one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst && !flush && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("alu_result", alu_result, e.res);
                chk("branch_address", branch_address, e.addr);
                chk("branch_taken", branch_taken, e.taken);
            end
        end
    end

    // Random output back-pressure during the random phase.
    always @(posedge clk) begin
        if (rand_bp) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Present one instruction (called just after a rising edge) and wait for its accept.
    task automatic drive_op(input logic [3:0] cmd, input logic [1:0] bt,
                            input logic [31:0] v1, input logic [31:0] v2,
                            input logic [31:0] s2, input logic [31:0] p, input exp_t e);
        bit acc = 1'b0;
        exe_cmd = cmd; branch_type = bt; val1 = v1; val2 = v2; src2_val = s2; pc = p;
        in_valid = 1'b1;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk);
            acc = in_ready && !flush;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (acc) exp_q.push_back(e);
        else     chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_cycles_no_output(input string name, input int n);
        int seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        @(posedge clk); #1;
        chk(name, seen, 0);
    endtask

    // Pulse reset for one cycle, check cleared outputs, then ADD 1+1 with latency 1.
    task automatic reset_then_add(input string tag);
        exp_t e;
        rst = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_rst_valid"}, out_valid, 0);
        chk({tag, "_rst_result"}, alu_result, 0);
        chk({tag, "_rst_addr"}, branch_address, 0);
        chk({tag, "_rst_taken"}, branch_taken, 0);
        rst = 1'b1;
        exp_q.delete();
        wait_cycles_no_output({tag, "_rst_no_out"}, 40);
        out_ready = 1'b1;
        e = '{32'd2, 32'd1, 1'b0};
        drive_op(CMD_ADD, BR_NONE, 32'd1, 32'd1, 32'd0, 32'd0, e);
        chk({tag, "_add_lat1_valid"}, out_valid, 1);
        chk({tag, "_add_lat1_result"}, alu_result, 2);
        @(posedge clk); #1;
    endtask

    initial begin
        exp_t e;
        int lat, busy;

        tbl[0]  = '{CMD_ADD, BR_NONE, 32'd5,         32'd7,         32'd0, 32'h100,      '{32'd12,        32'h107,      1'b0}};
        tbl[1]  = '{CMD_SUB, BR_NONE, 32'd9,         32'd2,         32'd0, 32'h200,      '{32'd7,         32'h202,      1'b0}};
        tbl[2]  = '{CMD_AND, BR_NONE, 32'hF0F0,      32'hFF00,      32'd0, 32'h0,        '{32'hF000,      32'hFF00,     1'b0}};
        tbl[3]  = '{CMD_OR,  BR_NONE, 32'hF0F0,      32'h0F00,      32'd0, 32'h10,       '{32'hFFF0,      32'h0F10,     1'b0}};
        tbl[4]  = '{CMD_NOR, BR_NONE, 32'd0,         32'd0,         32'd0, 32'h4,        '{32'hFFFFFFFF,  32'h4,        1'b0}};
        tbl[5]  = '{CMD_XOR, BR_NONE, 32'hAAAA5555,  32'hFFFF0000,  32'd0, 32'h0,        '{32'h55555555,  32'hFFFF0000, 1'b0}};
        tbl[6]  = '{CMD_SLL, BR_NONE, 32'd1,         32'h24,        32'd0, 32'h0,        '{32'h10,        32'h24,       1'b0}};
        tbl[7]  = '{CMD_SRL, BR_NONE, 32'h80000000,  32'd31,        32'd0, 32'h0,        '{32'd1,         32'h1F,       1'b0}};
        tbl[8]  = '{CMD_SRA, BR_NONE, 32'h80000000,  32'd4,         32'd0, 32'h0,        '{32'hF8000000,  32'h4,        1'b0}};
        tbl[9]  = '{CMD_SLT, BR_NONE, 32'hFFFFFFFF,  32'd1,         32'd0, 32'h0,        '{32'd1,         32'h1,        1'b0}};
        tbl[10] = '{CMD_SLT, BR_NONE, 32'd1,         32'hFFFFFFFF,  32'd0, 32'h0,        '{32'd0,         32'hFFFFFFFF, 1'b0}};
        tbl[11] = '{CMD_ADD, BR_BNE,  32'd3,         32'h10,        32'd4, 32'h40,       '{32'h13,        32'h50,       1'b1}};
        tbl[12] = '{CMD_ADD, BR_BNE,  32'd3,         32'h10,        32'd3, 32'h40,       '{32'h13,        32'h50,       1'b0}};
        tbl[13] = '{CMD_ADD, BR_BEZ,  32'd0,         32'd8,         32'd0, 32'h1000,     '{32'd8,         32'h1008,     1'b1}};
        tbl[14] = '{CMD_ADD, BR_BEZ,  32'd1,         32'd8,         32'd0, 32'h1000,     '{32'd9,         32'h1008,     1'b0}};
        tbl[15] = '{CMD_ADD, BR_JMP,  32'd0,         32'd8,         32'd0, 32'hFFFFFFFC, '{32'd8,         32'h4,        1'b1}};
        tbl[16] = '{4'd15,   BR_NONE, 32'd3,         32'd4,         32'd0, 32'h0,        '{32'd0,         32'h4,        1'b0}};
        tbl[17] = '{CMD_ADD, BR_NONE, 32'hFFFFFFFF,  32'd1,         32'd0, 32'h0,        '{32'd0,         32'h1,        1'b0}};
        tbl[18] = '{CMD_MUL, BR_NONE, 32'd3,         32'd4,         32'd0, 32'h0,        '{MUL_3X4,       32'h4,        1'b0}};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_alu_result", alu_result, 0);
        chk("reset_branch_address", branch_address, 0);
        chk("reset_branch_taken", branch_taken, 0);
        chk("reset_in_ready", in_ready, 1);
        rst = 1'b1;
        @(posedge clk); #1;

        // Vector table, back-to-back at full throughput
        out_ready = 1'b1;
        for (int i = 0; i < NV; i++)
            drive_op(tbl[i].cmd, tbl[i].bt, tbl[i].v1, tbl[i].v2, tbl[i].s2, tbl[i].p, tbl[i].e);
        for (int n = 0; n < 100 && exp_q.size() != 0; n++) begin
            @(posedge clk); #1;
        end
        chk("table_drained", exp_q.size(), 0);

        // Back-pressure: SUB held for 3 cycles, then consume and accept ADD on the same edge
        out_ready = 1'b0;
        drive_op(CMD_SUB, BR_NONE, 32'd9, 32'd2, 32'd0, 32'd0, '{32'd7, 32'd2, 1'b0});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_hold_result", alu_result, 7);
            chk("bp_in_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        drive_op(CMD_ADD, BR_NONE, 32'd1, 32'd2, 32'd0, 32'd0, '{32'd3, 32'd2, 1'b0});
        chk("bp_replace_valid", out_valid, 1);
        chk("bp_replace_result", alu_result, 3);
        @(posedge clk); #1;
        chk("bp_drained", exp_q.size(), 0);

        // Flush with a held result and a same-cycle request: both are dropped
        out_ready = 1'b0;
        drive_op(CMD_ADD, BR_NONE, 32'd4, 32'd4, 32'd0, 32'd0, '{32'd8, 32'd4, 1'b0});
        exe_cmd = CMD_ADD; val1 = 32'd6; val2 = 32'd6; branch_type = BR_NONE;
        in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        chk("flush_clears_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        out_ready = 1'b1;
        wait_cycles_no_output("flush_drops_accept", 5);

        reset_then_add("sc");

`ifdef EXE_MUL_EN
        // MUL 0xFFFFFFFF * 2: 32 busy cycles, result on cycle 33
        out_ready = 1'b1;
        exe_cmd = CMD_MUL; branch_type = BR_NONE; val1 = 32'hFFFFFFFF; val2 = 32'd2; pc = 32'd0;
        in_valid = 1'b1;
        @(negedge clk);
        chk("mul_in_ready_idle", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_q.push_back('{32'hFFFFFFFE, 32'd2, 1'b0});
        lat = 1;
        busy = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            if (!in_ready) busy++;
            @(posedge clk); #1;
            lat++;
        end
        chk("mul_latency", lat, 33);
        chk("mul_busy_cycles", busy, 32);
        chk("mul_result_direct", alu_result, 32'hFFFFFFFE);
        @(posedge clk); #1;
        chk("mul_drained", exp_q.size(), 0);

        // Flush at multiply step 10
        drive_op(CMD_MUL, BR_NONE, 32'd7, 32'd9, 32'd0, 32'd0, '{32'd63, 32'd9, 1'b0});
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        exp_q.delete();
        chk("mul_flush_valid", out_valid, 0);
        chk("mul_flush_in_ready", in_ready, 1);
        wait_cycles_no_output("mul_flush_no_out", 40);

        // Reset mid-multiply
        drive_op(CMD_MUL, BR_NONE, 32'd5, 32'd5, 32'd0, 32'd0, '{32'd25, 32'd5, 1'b0});
        repeat (5) @(posedge clk);
        #1;
        reset_then_add("mul");
`endif

        // Random phase with random back-pressure and idle gaps
        rand_bp = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [3:0]  c;
            logic [1:0]  b;
            logic [31:0] a, v, s, p;
`ifdef EXE_MUL_EN
            c = 4'($urandom_range(0, 10));
`else
            c = 4'($urandom_range(0, 9));
`endif
            b = 2'($urandom_range(0, 3));
            a = $urandom();
            v = $urandom();
            s = ($urandom_range(0, 1) == 1) ? a : $urandom();
            p = $urandom();
            if ($urandom_range(0, 3) == 0) a = 32'd0;
            drive_op(c, b, a, v, s, p, model(c, b, a, v, s, p));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        rand_bp = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        for (int n = 0; n < 200 && exp_q.size() != 0; n++) begin
            @(posedge clk); #1;
        end
        chk("random_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
